mipi_csi2_pkt_parser: RTL and testbench
=======================================

// Module: mipi_csi2_pkt_parser
// PURPOSE
//  CSI-2 low-level protocol parser directly downstream of the MIPI PHY deserializer. Takes its merged
//  byte stream (burst enable + per-byte valid) and splits each HS burst into packet header / payload / CRC.
//  Checks header ECC and payload CRC, and drives frame/line framing plus a byte-wide payload stream
//  to the pixel unpacker.
// PARAMETERS
//  CHECK_CRC   1   1: compare payload CRC-16 and pulse crc_err; 0: CRC bytes consumed, never checked
//  DROP_ECC    1   1: header with ECC mismatch is discarded to end of burst; 0: flag only, then parse
// PORTS
//  clk          in   1   byte clock, same as PHY output clk
//  reset        in   1   synchronous, active-high
//  in_we        in   1   HS burst active (high from first byte to LP entry)
//  in_dvo       in   1   in_data valid this cycle (qualifies bytes only while in_we=1)
//  in_data      in   8   byte, CSI-2 transmission order
//  hdr_valid    out  1   1-cycle pulse: vc/dt/wc updated from an accepted header
//  vc           out  2   virtual channel of last header
//  dt           out  6   data type of last header
//  wc           out  16  word count (long pkt) / short-packet data field
//  frame_valid  out  1   high from Frame Start to Frame End
//  line_valid   out  1   high while a long-packet payload is streaming
//  pix_we       out  1   payload byte valid
//  pix_data     out  8   payload byte
//  pix_last     out  1   with pix_we: final payload byte of packet
//  ecc_err      out  1   1-cycle pulse: header ECC mismatch or DI/ECC byte bits [7:6] != 0
//  crc_err      out  1   1-cycle pulse, cycle after 2nd CRC byte, CRC mismatch
//  trunc_err    out  1   1-cycle pulse: in_we fell before packet complete
// BEHAVIOUR
//  Decided: one clock; reset is synchronous and active-high. All outputs 0 on reset (vc/dt/wc=0).
//  A byte is accepted only when in_we & in_dvo. Stalls (in_dvo=0 within a burst) are legal anywhere.
//  FSM: IDLE -> HDR -> (PAYLOAD -> CRC) -> TRAIL; any state -> IDLE when in_we=0.
//   IDLE: first accepted byte of a burst; if 8'hB8 it is dropped as sync. Otherwise it is header byte 0.
//    Go HDR.
//   HDR: collect DI, WC_lo, WC_hi, ECC (4 bytes). On the 4th byte, compute ECC over the 24-bit header
//    (package fn).
//    -ECC bad: ecc_err next cycle. If DROP_ECC, go TRAIL with no hdr_valid.
//    -dt<=0x0F (short): hdr_valid. FS(0x00): frame_valid<=1. FE(0x01): frame_valid<=0, line_valid<=0.
//     Other short DTs: hdr_valid only. Go TRAIL.
//    -dt>=0x10 (long): hdr_valid, line_valid<=1. wc==0 -> CRC directly, else PAYLOAD.
//   PAYLOAD: each accepted byte -> pix_we/pix_data registered, 1-cycle latency. A 16-bit down-counter
//    is loaded with wc; pix_last on the byte that takes the counter to 0. line_valid<=0 with that byte.
//    Go CRC.
//   CRC: 2 bytes, LS byte first. CRC-16 poly x^16+x^12+x^5+1, LSB-first, init 0xFFFF, no final xor,
//    over payload bytes only. Mismatch & CHECK_CRC -> crc_err. Go TRAIL.
//   TRAIL: accepted bytes ignored (trailer/filler) until in_we=0. One packet per burst.
//  in_we falls in HDR/PAYLOAD/CRC: trunc_err pulse, line_valid<=0, no pix_last. frame_valid unchanged.
//  in_we falls in the same cycle as an accepted byte: that byte is ignored (in_we gates acceptance).
//  FS while frame_valid=1: stays 1 (restart). FE while frame_valid=0: stays 0. No error for either.
//  hdr_valid and ecc_err are mutually exclusive when DROP_ECC=1. With DROP_ECC=0 both may pulse
//   in the same cycle.
//  Reset mid-packet: everything cleared, FSM to IDLE. The next burst must start fresh (in_we low first).
//  After reset, or after an in_we fall, IDLE waits for in_we=0 before arming.
// STRUCTURE
//  mipi_csi2_pkg: DT_FS/DT_FE/DT_LS/DT_LE/DT_LONG_MIN constants, SYNC_BYTE=8'hB8, FSM state enum,
//   function csi2_ecc(input [23:0]) -> [5:0], function crc16_byte(crc, byte).
//  Sub-module mipi_csi2_crc16: clr/en/byte in, 16-bit crc out (clear on HDR->PAYLOAD/CRC transition).
// TESTING
//  1 Short FS: B8,00,01,00,ecc(0x000100). Expect hdr_valid, vc=0 dt=0 wc=1, frame_valid=1, no errors.
//  2 Long RAW8: B8,2A,04,00,ecc,11,22,33,44,crc_lo,crc_hi (model). Expect pix 11,22,33,44 with pix_last
//    on 44, line_valid 4 bytes, no crc_err. Repeat with in_dvo gaps: identical output.
//  3 wc=0 long: 2A,00,00,ecc,FF,FF. Expect hdr_valid, no pix_we, no crc_err (empty CRC=0xFFFF).
//    Corrupt CRC to 0000: crc_err.
//  4 Flip header bit 3 of WC_lo: ecc_err, no hdr_valid, no pix_we for rest of burst. Next burst parses.
//  5 Drop in_we after 2 payload bytes of wc=4: trunc_err, line_valid low, frame_valid retained.
//  6 FE after FS: frame_valid falls the cycle after the ECC byte. Reset asserted mid-payload: all outputs 0.

Source files
------------

// File: rtl/mipi_csi2_pkg.sv
// Shared definitions for the CSI-2 low-level packet parser.
//   - data type constants used for short/long packet decoding
//   - leading sync byte value
//   - parser FSM state enum
//   - csi2_ecc:   6-bit Hamming ECC over the 24-bit packet header {WC_hi, WC_lo, DI}
//   - crc16_byte: one byte step of CRC-16 x^16+x^12+x^5+1, LSB-first (reflected poly 0x8408)
package mipi_csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam logic [7:0] SYNC_BYTE   = 8'hB8;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPayload,
        StCrc,
        StTrail
    } parser_state_e;

    // Header bit d[0] is DI bit 0 (first byte on the wire), d[23] is WC_hi bit 7.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^
               d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^
               d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^
               d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^
               d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
               d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
               d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // Bit-serial, data bit 0 first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_csi2_crc16.sv
// Running CRC-16 over the payload bytes of one long packet.
// Ports:
//   clk, reset  byte clock, synchronous active-high reset
//   clr         reload the seed 0xFFFF (start of a new packet)
//   en          fold data into the running CRC
//   data        payload byte
//   crc         current CRC value (no final xor)
module mipi_csi2_crc16
    import mipi_csi2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc_q <= 16'hFFFF;
        end else if (en) begin
            crc_q <= crc16_byte(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mipi_csi2_pkt_parser.sv
// CSI-2 low-level protocol parser. Splits each HS burst from the PHY deserializer into header,
// payload and CRC; checks header ECC and payload CRC; drives frame/line framing and a byte-wide
// payload stream.
// Ports:
//   clk, reset                    byte clock, synchronous active-high reset
//   in_we, in_dvo, in_data        burst active, byte valid, byte (accepted when in_we & in_dvo)
//   hdr_valid, vc, dt, wc         pulse + fields of the last accepted header
//   frame_valid, line_valid       framing levels
//   pix_we, pix_data, pix_last    payload byte stream, 1-cycle latency
//   ecc_err, crc_err, trunc_err   single-cycle error pulses
module mipi_csi2_pkt_parser
    import mipi_csi2_pkg::*;
#(
    parameter bit CHECK_CRC = 1'b1,
    parameter bit DROP_ECC  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_we,
    input  logic        in_dvo,
    input  logic [7:0]  in_data,
    output logic        hdr_valid,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        frame_valid,
    output logic        line_valid,
    output logic        pix_we,
    output logic [7:0]  pix_data,
    output logic        pix_last,
    output logic        ecc_err,
    output logic        crc_err,
    output logic        trunc_err
);

    parser_state_e state_q, state_d;
    logic          armed_q, armed_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    di_q, di_d;
    logic [7:0]    wc_lo_q, wc_lo_d;
    logic [7:0]    wc_hi_q, wc_hi_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    crc_lo_q, crc_lo_d;

    logic          hdr_valid_q, hdr_valid_d;
    logic [1:0]    vc_q, vc_d;
    logic [5:0]    dt_q, dt_d;
    logic [15:0]   wc_q, wc_d;
    logic          frame_valid_q, frame_valid_d;
    logic          line_valid_q, line_valid_d;
    logic          pix_we_q, pix_we_d;
    logic [7:0]    pix_data_q, pix_data_d;
    logic          pix_last_q, pix_last_d;
    logic          ecc_err_q, ecc_err_d;
    logic          crc_err_q, crc_err_d;
    logic          trunc_err_q, trunc_err_d;

    logic          crc_clr;
    logic          crc_en;
    logic [15:0]   crc_val;

    logic [15:0]   hdr_wc;
    logic [5:0]    hdr_dt;
    logic          hdr_bad;

    mipi_csi2_crc16 u_crc16 (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (in_data),
        .crc   (crc_val)
    );

    // Header fields as seen when the ECC byte is on in_data. The ECC byte's upper two bits are
    // reserved and must be zero; DI[7:6] carries the virtual channel and is not checked.
    assign hdr_wc  = {wc_hi_q, wc_lo_q};
    assign hdr_dt  = di_q[5:0];
    assign hdr_bad = (csi2_ecc({wc_hi_q, wc_lo_q, di_q}) != in_data[5:0]) ||
                     (in_data[7:6] != 2'b00);

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        byte_idx_d    = byte_idx_q;
        di_d          = di_q;
        wc_lo_d       = wc_lo_q;
        wc_hi_d       = wc_hi_q;
        cnt_d         = cnt_q;
        crc_lo_d      = crc_lo_q;
        hdr_valid_d   = 1'b0;
        vc_d          = vc_q;
        dt_d          = dt_q;
        wc_d          = wc_q;
        frame_valid_d = frame_valid_q;
        line_valid_d  = line_valid_q;
        pix_we_d      = 1'b0;
        pix_data_d    = pix_data_q;
        pix_last_d    = 1'b0;
        ecc_err_d     = 1'b0;
        crc_err_d     = 1'b0;
        trunc_err_d   = 1'b0;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;

        if (!in_we) begin
            // Burst ended: arm for the next one. A byte presented with in_we low is ignored.
            state_d = StIdle;
            armed_d = 1'b1;
            if (state_q == StHdr || state_q == StPayload || state_q == StCrc) begin
                trunc_err_d  = 1'b1;
                line_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Not armed means the burst was already running when we came out of reset
                    // or aborted; sit it out until in_we drops.
                    if (armed_q && in_dvo) begin
                        armed_d = 1'b0;
                        state_d = StHdr;
                        if (in_data == SYNC_BYTE) begin
                            byte_idx_d = 2'd0;
                        end else begin
                            di_d       = in_data;
                            byte_idx_d = 2'd1;
                        end
                    end
                end

                StHdr: begin
                    if (in_dvo) begin
                        // Wraps 3 -> 0, which also primes the CRC byte index.
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: di_d    = in_data;
                            2'd1: wc_lo_d = in_data;
                            2'd2: wc_hi_d = in_data;
                            2'd3: begin
                                ecc_err_d = hdr_bad;
                                if (hdr_bad && DROP_ECC) begin
                                    state_d = StTrail;
                                end else begin
                                    hdr_valid_d = 1'b1;
                                    vc_d        = di_q[7:6];
                                    dt_d        = hdr_dt;
                                    wc_d        = hdr_wc;
                                    if (hdr_dt < DT_LONG_MIN) begin
                                        if (hdr_dt == DT_FS) begin
                                            frame_valid_d = 1'b1;
                                        end else if (hdr_dt == DT_FE) begin
                                            frame_valid_d = 1'b0;
                                            line_valid_d  = 1'b0;
                                        end
                                        state_d = StTrail;
                                    end else begin
                                        crc_clr = 1'b1;
                                        cnt_d   = hdr_wc;
                                        if (hdr_wc == 16'd0) begin
                                            // No payload, so no line to frame.
                                            state_d = StCrc;
                                        end else begin
                                            line_valid_d = 1'b1;
                                            state_d      = StPayload;
                                        end
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StPayload: begin
                    if (in_dvo) begin
                        pix_we_d   = 1'b1;
                        pix_data_d = in_data;
                        crc_en     = 1'b1;
                        cnt_d      = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            pix_last_d   = 1'b1;
                            line_valid_d = 1'b0;
                            state_d      = StCrc;
                        end
                    end
                end

                StCrc: begin
                    if (in_dvo) begin
                        if (byte_idx_q == 2'd0) begin
                            crc_lo_d   = in_data;
                            byte_idx_d = 2'd1;
                        end else begin
                            crc_err_d = CHECK_CRC && ({in_data, crc_lo_q} != crc_val);
                            state_d   = StTrail;
                        end
                    end
                end

                StTrail: ;

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            armed_q       <= 1'b0;
            byte_idx_q    <= 2'd0;
            di_q          <= 8'd0;
            wc_lo_q       <= 8'd0;
            wc_hi_q       <= 8'd0;
            cnt_q         <= 16'd0;
            crc_lo_q      <= 8'd0;
            hdr_valid_q   <= 1'b0;
            vc_q          <= 2'd0;
            dt_q          <= 6'd0;
            wc_q          <= 16'd0;
            frame_valid_q <= 1'b0;
            line_valid_q  <= 1'b0;
            pix_we_q      <= 1'b0;
            pix_data_q    <= 8'd0;
            pix_last_q    <= 1'b0;
            ecc_err_q     <= 1'b0;
            crc_err_q     <= 1'b0;
            trunc_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            byte_idx_q    <= byte_idx_d;
            di_q          <= di_d;
            wc_lo_q       <= wc_lo_d;
            wc_hi_q       <= wc_hi_d;
            cnt_q         <= cnt_d;
            crc_lo_q      <= crc_lo_d;
            hdr_valid_q   <= hdr_valid_d;
            vc_q          <= vc_d;
            dt_q          <= dt_d;
            wc_q          <= wc_d;
            frame_valid_q <= frame_valid_d;
            line_valid_q  <= line_valid_d;
            pix_we_q      <= pix_we_d;
            pix_data_q    <= pix_data_d;
            pix_last_q    <= pix_last_d;
            ecc_err_q     <= ecc_err_d;
            crc_err_q     <= crc_err_d;
            trunc_err_q   <= trunc_err_d;
        end
    end

    assign hdr_valid   = hdr_valid_q;
    assign vc          = vc_q;
    assign dt          = dt_q;
    assign wc          = wc_q;
    assign frame_valid = frame_valid_q;
    assign line_valid  = line_valid_q;
    assign pix_we      = pix_we_q;
    assign pix_data    = pix_data_q;
    assign pix_last    = pix_last_q;
    assign ecc_err     = ecc_err_q;
    assign crc_err     = crc_err_q;
    assign trunc_err   = trunc_err_q;

endmodule

// File: tb/tb_mipi_csi2_pkt_parser.sv
// Directed bench for mipi_csi2_pkt_parser. A negedge monitor tallies output events per scenario;
// each test task drives one or more bursts and compares tallies/levels with hand-derived values.
module tb_mipi_csi2_pkt_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_we = 1'b0;
    logic        in_dvo = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        hdr_valid;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        frame_valid;
    logic        line_valid;
    logic        pix_we;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        ecc_err;
    logic        crc_err;
    logic        trunc_err;

    int checks = 0;
    int errors = 0;

    // Monitor tallies
    int         n_hdr, n_ecc, n_crc, n_trunc, n_pix, n_last, last_idx;
    bit         lv_seen;
    logic [7:0] pix_buf [0:15];

    logic [7:0] burst [$];

    mipi_csi2_pkt_parser dut (
        .clk         (clk),
        .reset       (reset),
        .in_we       (in_we),
        .in_dvo      (in_dvo),
        .in_data     (in_data),
        .hdr_valid   (hdr_valid),
        .vc          (vc),
        .dt          (dt),
        .wc          (wc),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .pix_we      (pix_we),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .ecc_err     (ecc_err),
        .crc_err     (crc_err),
        .trunc_err   (trunc_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hdr_valid) n_hdr++;
        if (ecc_err) n_ecc++;
        if (crc_err) n_crc++;
        if (trunc_err) n_trunc++;
        if (line_valid) lv_seen = 1'b1;
        if (pix_we) begin
            if (n_pix < 16) pix_buf[n_pix] = pix_data;
            if (pix_last) begin
                n_last++;
                last_idx = n_pix;
            end
            n_pix++;
        end
    end

    // Reflected CCITT byte update in the shift-and-xor form (independent of bit-serial loops).
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] d);
        logic [7:0] x;
        x = d ^ crc[7:0];
        x = x ^ (x << 4);
        return (crc >> 8) ^ {x, 8'h00} ^ {5'b0, x, 3'b000} ^ {12'h000, x[7:4]};
    endfunction

    task automatic clear_mon();
        n_hdr = 0; n_ecc = 0; n_crc = 0; n_trunc = 0; n_pix = 0; n_last = 0;
        last_idx = -1; lv_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_we = 1'b1; in_dvo = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_dvo = 1'b0;
    endtask

    // Sends the burst queue; with gaps, inserts stall cycles carrying junk data.
    task automatic send_burst(input bit gaps);
        for (int i = 0; i < burst.size(); i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_we = 1'b1; in_dvo = 1'b0; in_data = 8'h5A;
                @(posedge clk); #1;
                @(posedge clk); #1;
            end
            send_byte(burst[i]);
        end
    endtask

    task automatic end_burst();
        in_we = 1'b0; in_dvo = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hdr_valid, vc, dt, wc, frame_valid, line_valid, pix_we, pix_data, pix_last,
             ecc_err, crc_err, trunc_err} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vc=%h dt=%h wc=%h fv=%b lv=%b pix=%h required all 0",
                     vc, dt, wc, frame_valid, line_valid, pix_data);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_short_fs();
        clear_mon();
        burst = '{8'hB8, 8'h00, 8'h01, 8'h00, 8'h1A};
        send_burst(1'b0);
        end_burst();
        checks++; if (n_hdr !== 1) begin errors++; $display("FAIL fs_hdr_valid: got %0d required 1", n_hdr); end
        checks++; if ({vc, dt, wc} !== {2'd0, 6'h00, 16'h0001}) begin errors++;
            $display("FAIL fs_fields: got vc=%h dt=%h wc=%h required 0/00/0001", vc, dt, wc); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fs_frame_valid: got %b required 1", frame_valid); end
        checks++; if (n_ecc + n_crc + n_trunc + n_pix !== 0) begin errors++;
            $display("FAIL fs_no_errors: got ecc=%0d crc=%0d trunc=%0d pix=%0d required 0",
                     n_ecc, n_crc, n_trunc, n_pix); end
    endtask

    task automatic test_long_raw8(input bit gaps);
        logic [7:0]  exp_pix [0:3];
        logic [15:0] c;
        exp_pix[0] = 8'h11; exp_pix[1] = 8'h22; exp_pix[2] = 8'h33; exp_pix[3] = 8'h44;
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) c = crc_step(c, exp_pix[i]);
        clear_mon();
        burst = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22, 8'h33, 8'h44};
        burst.push_back(c[7:0]);
        burst.push_back(c[15:8]);
        send_burst(gaps);
        end_burst();
        checks++; if (n_hdr !== 1 || dt !== 6'h2A || wc !== 16'd4) begin errors++;
            $display("FAIL long_hdr gaps=%0d: got n=%0d dt=%h wc=%h required 1/2A/0004", gaps, n_hdr, dt, wc); end
        checks++; if (n_pix !== 4) begin errors++;
            $display("FAIL long_pix_count gaps=%0d: got %0d required 4", gaps, n_pix); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pix_buf[i] !== exp_pix[i]) begin errors++;
                $display("FAIL long_pix_data[%0d] gaps=%0d: got %h required %h", i, gaps, pix_buf[i], exp_pix[i]); end
        end
        checks++; if (n_last !== 1 || last_idx !== 3) begin errors++;
            $display("FAIL long_pix_last gaps=%0d: got n=%0d idx=%0d required 1/3", gaps, n_last, last_idx); end
        checks++; if (lv_seen !== 1'b1 || line_valid !== 1'b0) begin errors++;
            $display("FAIL long_line_valid gaps=%0d: got seen=%b end=%b required 1/0", gaps, lv_seen, line_valid); end
        checks++; if (n_crc !== 0 || n_ecc !== 0 || n_trunc !== 0) begin errors++;
            $display("FAIL long_no_errors gaps=%0d: got crc=%0d ecc=%0d trunc=%0d required 0", gaps, n_crc, n_ecc, n_trunc); end
        checks++; if (frame_valid !== 1'b1) begin errors++;
            $display("FAIL long_frame_kept gaps=%0d: got %b required 1", gaps, frame_valid); end
    endtask

    task automatic test_wc0();
        clear_mon();
        burst = '{8'h2A, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF};
        send_burst(1'b0);
        end_burst();
        checks++; if (n_hdr !== 1 || wc !== 16'd0) begin errors++;
            $display("FAIL wc0_hdr: got n=%0d wc=%h required 1/0000", n_hdr, wc); end
        checks++; if (n_pix !== 0 || n_crc !== 0) begin errors++;
            $display("FAIL wc0_clean: got pix=%0d crc=%0d required 0/0", n_pix, n_crc); end
        clear_mon();
        burst = '{8'h2A, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        send_burst(1'b0);
        end_burst();
        checks++; if (n_crc !== 1) begin errors++;
            $display("FAIL wc0_crc_err: got %0d required 1", n_crc); end
    endtask

    task automatic test_ecc_drop();
        clear_mon();
        // WC_lo bit 3 flipped (04 -> 0C), ECC left as for the good header
        burst = '{8'hB8, 8'h2A, 8'h0C, 8'h00, 8'h33, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        send_burst(1'b0);
        end_burst();
        checks++; if (n_ecc !== 1) begin errors++; $display("FAIL ecc_err_pulse: got %0d required 1", n_ecc); end
        checks++; if (n_hdr !== 0) begin errors++; $display("FAIL ecc_no_hdr: got %0d required 0", n_hdr); end
        checks++; if (n_pix !== 0 || lv_seen !== 1'b0 || n_crc !== 0) begin errors++;
            $display("FAIL ecc_drop_rest: got pix=%0d lv=%b crc=%0d required 0/0/0", n_pix, lv_seen, n_crc); end
        test_long_raw8(1'b0);
    endtask

    task automatic test_trunc();
        clear_mon();
        burst = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22};
        send_burst(1'b0);
        // Byte presented in the same cycle in_we falls must be ignored.
        in_we = 1'b0; in_dvo = 1'b1; in_data = 8'h33;
        @(posedge clk); #1;
        end_burst();
        checks++; if (n_trunc !== 1) begin errors++; $display("FAIL trunc_pulse: got %0d required 1", n_trunc); end
        checks++; if (n_pix !== 2 || n_last !== 0) begin errors++;
            $display("FAIL trunc_pix: got pix=%0d last=%0d required 2/0", n_pix, n_last); end
        checks++; if (line_valid !== 1'b0 || frame_valid !== 1'b1) begin errors++;
            $display("FAIL trunc_levels: got lv=%b fv=%b required 0/1", line_valid, frame_valid); end
    endtask

    task automatic test_fe();
        clear_mon();
        burst = '{8'hB8, 8'h01, 8'h01, 8'h00};
        send_burst(1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++;
            $display("FAIL fe_before_ecc: got %b required 1", frame_valid); end
        send_byte(8'h1D);
        checks++; if (frame_valid !== 1'b0 || hdr_valid !== 1'b1 || dt !== 6'h01) begin errors++;
            $display("FAIL fe_after_ecc: got fv=%b hv=%b dt=%h required 0/1/01", frame_valid, hdr_valid, dt); end
        end_burst();
        clear_mon();
        burst = '{8'hB8, 8'h01, 8'h01, 8'h00, 8'h1D};
        send_burst(1'b0);
        end_burst();
        checks++; if (frame_valid !== 1'b0 || n_hdr !== 1 || n_ecc !== 0) begin errors++;
            $display("FAIL fe_repeat: got fv=%b n_hdr=%0d ecc=%0d required 0/1/0", frame_valid, n_hdr, n_ecc); end
    endtask

    task automatic test_reset_mid();
        burst = '{8'hB8, 8'h00, 8'h01, 8'h00, 8'h1A};
        send_burst(1'b0);
        end_burst();
        burst = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22};
        send_burst(1'b0);
        checks++; if (line_valid !== 1'b1 || frame_valid !== 1'b1) begin errors++;
            $display("FAIL mid_pre_reset: got lv=%b fv=%b required 1/1", line_valid, frame_valid); end
        reset = 1'b1; in_we = 1'b1; in_dvo = 1'b1; in_data = 8'h33;
        @(posedge clk); #1;
        checks++;
        if ({hdr_valid, vc, dt, wc, frame_valid, line_valid, pix_we, pix_data, pix_last,
             ecc_err, crc_err, trunc_err} !== 41'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got dt=%h wc=%h fv=%b lv=%b pix=%h required all 0",
                     dt, wc, frame_valid, line_valid, pix_data);
        end
        reset = 1'b0;
        clear_mon();
        // Burst still running after reset: must be ignored until in_we drops.
        burst = '{8'hB8, 8'h00, 8'h01, 8'h00, 8'h1A};
        send_burst(1'b0);
        end_burst();
        checks++; if (n_hdr !== 0 || frame_valid !== 1'b0) begin errors++;
            $display("FAIL mid_unarmed: got n_hdr=%0d fv=%b required 0/0", n_hdr, frame_valid); end
        clear_mon();
        send_burst(1'b0);
        end_burst();
        checks++; if (n_hdr !== 1 || frame_valid !== 1'b1) begin errors++;
            $display("FAIL mid_rearmed: got n_hdr=%0d fv=%b required 1/1", n_hdr, frame_valid); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_short_fs();
        test_long_raw8(1'b0);
        test_long_raw8(1'b1);
        test_wc0();
        test_ecc_drop();
        test_trunc();
        test_fe();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
